// File: rtl/ntt_coeff_loader_if.sv
// Coefficient stream into the NTT loader.
// A beat transfers on a rising clk edge where s_valid && s_ready are both high.
// While s_ready is low, the source holds s_valid and s_data stable.
interface ntt_coeff_loader_if #(
  parameter int DWIDTH = 12
);
  logic              s_valid;
  logic [DWIDTH-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ntt_coeff_loader.sv
// Streams N raw coefficients, reduces each into [0, Q) and writes them into the
// NTT core RAM in natural or bit-reversed order. It then kicks the core and waits for done.
module ntt_coeff_loader #(
  parameter int N          = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int DWIDTH     = 12,
  parameter int Q          = 3329,
  parameter int BITREV     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  ntt_coeff_loader_if.slave     s,
  output logic                  ntt_ext_we,
  output logic [ADDR_WIDTH-1:0] ntt_ext_addr,
  output logic [DWIDTH-1:0]     ntt_ext_data,
  output logic                  ntt_start,
  input  logic                  ntt_done,
  output logic                  busy,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   reduce_cnt,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    FLUSH = 3'd1,
    KICK  = 3'd2,
    WAIT  = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
  localparam logic [DWIDTH-1:0]     Q_W      = DWIDTH'(Q);
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   RED_ONE  = (ADDR_WIDTH + 1)'(1);

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic                    busy_r;
  logic                    ready;
  logic                    accept;
  logic                    red_sub;
  logic [DWIDTH-1:0]       red_data;

  function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] r;
    for (int i = 0; i < ADDR_WIDTH; i++) r[i] = a[ADDR_WIDTH-1-i];
    return r;
  endfunction

  // Ready is masked during reset so nothing is claimed on a cycle that is discarded.
  assign ready     = (state == LOAD) && !rst;
  assign accept    = s.s_valid && ready;
  assign s.s_ready = ready;

  // Raw data is below 2Q, so one conditional subtract fully reduces it.
  assign red_sub  = (s.s_data >= Q_W);
  assign red_data = red_sub ? (s.s_data - Q_W) : s.s_data;
  assign waddr    = (BITREV != 0) ? bitrev(cnt) : cnt;

  always_comb begin
    state_next = state;
    ntt_start  = 1'b0;
    load_done  = 1'b0;
    case (state)
      LOAD:    if (accept && (cnt == LAST_IDX)) state_next = FLUSH;
      FLUSH:   state_next = KICK;
      KICK: begin
        ntt_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT:    if (ntt_done) state_next = FIN;
      FIN: begin
        load_done  = 1'b1;
        state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD;
      cnt          <= '0;
      reduce_cnt   <= '0;
      busy_r       <= 1'b0;
      ntt_ext_we   <= 1'b0;
      ntt_ext_addr <= '0;
      ntt_ext_data <= '0;
    end else begin
      state      <= state_next;
      ntt_ext_we <= accept;
      if (accept) begin
        ntt_ext_addr <= waddr;
        ntt_ext_data <= red_data;
        cnt          <= cnt + CNT_ONE;
        busy_r       <= 1'b1;
        if (red_sub) reduce_cnt <= reduce_cnt + RED_ONE;
      end
      if (state == FIN) begin
        cnt        <= '0;
        reduce_cnt <= '0;
        busy_r     <= 1'b0;
      end
    end
  end

  // busy drops in the same cycle that load_done pulses.
  assign busy      = busy_r && (state != FIN);
  assign dbg_state = state;

endmodule
